// File: rtl/cache_tag_lookup.sv
// -----------------------------------------------------------------------------
// cache_tag_lookup
//
// Tag lookup and miss-fill controller for a 4-line fully associative cache.
// It holds valid/tag/data storage for the 4 ways and compares each CPU request
// tag against every valid way. A hit reports the matching way to the LRU unit
// and returns the stored data. A miss fetches the line over a req/ack memory
// handshake and fills a victim way: the lowest invalid way, otherwise the way
// the LRU unit offers on lru_way.
//
// Optional feature macro: CACHE_HIT_COUNTER_EN
//   When defined, adds saturating 16-bit hit_cnt / miss_cnt outputs. Each one
//   counts LOOKUP cycles with the matching result.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   req_valid   in   CPU request present
//   req_tag     in   CPU request tag [TAG_W]
//   req_ready   out  request accepted this cycle (IDLE)
//   lru_way     in   victim way from the LRU unit
//   hit         out  lookup result (LOOKUP only)
//   line_index  out  accessed / filled way
//   lru_update  out  strobe: record line_index as most recently used
//   mem_req     out  memory fetch request
//   mem_tag     out  tag being fetched [TAG_W]
//   mem_ack     in   memory data valid
//   mem_data    in   fetched line data [DATA_W]
//   resp_valid  out  one-cycle response strobe
//   resp_data   out  response data [DATA_W]
//   hit_cnt     out  hit counter  (CACHE_HIT_COUNTER_EN only)
//   miss_cnt    out  miss counter (CACHE_HIT_COUNTER_EN only)
// -----------------------------------------------------------------------------
module cache_tag_lookup #(
    parameter int TAG_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              req_ready,
    input  logic [1:0]        lru_way,
    output logic              hit,
    output logic [1:0]        line_index,
    output logic              lru_update,
    output logic              mem_req,
    output logic [TAG_W-1:0]  mem_tag,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data
`ifdef CACHE_HIT_COUNTER_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Line storage
    logic [3:0]        r_valid;
    logic [TAG_W-1:0]  r_tag  [4];
    logic [DATA_W-1:0] r_data [4];

    // Request context
    logic [TAG_W-1:0]  r_req_tag;
    logic [1:0]        r_fill_way;
    logic              r_was_hit;
    logic [1:0]        r_line_index;
    logic [TAG_W-1:0]  r_mem_tag;
    logic [DATA_W-1:0] r_resp_data;

    logic [3:0] w_match_vec;
    logic       w_lookup_hit;
    logic [1:0] w_match_way;
    logic [1:0] w_fill_way;
    logic       w_fill_ack;

    // Tag compare and the two lowest-index priority encoders. Scanning from
    // way 3 down to way 0 leaves the lowest index as the final assignment.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned, which would otherwise infer a latch.
        w_match_vec = '0;
        w_match_way = 2'd0;
        w_fill_way  = lru_way;
        for (int i = 3; i >= 0; i--) begin
            w_match_vec[i] = r_valid[i] && (r_tag[i] == r_req_tag);
            if (w_match_vec[i]) begin
                w_match_way = 2'(i);
            end
            if (!r_valid[i]) begin
                w_fill_way = 2'(i);
            end
        end
        w_lookup_hit = |w_match_vec;
    end

    assign w_fill_ack = (r_state == S_MEM_WAIT) && mem_ack;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state <= w_next_state;
        end
    end

    // Next state and outputs
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        hit          = 1'b0;
        lru_update   = 1'b0;
        mem_req      = 1'b0;
        resp_valid   = 1'b0;
        line_index   = r_line_index;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit = w_lookup_hit;
                if (w_lookup_hit) begin
                    line_index   = w_match_way;
                    lru_update   = 1'b1;
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                // A fill is reported to the LRU unit only once data is back.
                if (!r_was_hit) begin
                    lru_update = 1'b1;
                    line_index = r_fill_way;
                end
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign mem_tag   = r_mem_tag;
    assign resp_data = r_resp_data;

    // Control registers and valid bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= '0;
            r_req_tag    <= '0;
            r_fill_way   <= 2'd0;
            r_was_hit    <= 1'b0;
            r_line_index <= 2'd0;
            r_mem_tag    <= '0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_tag <= req_tag;
                    end
                end
                S_LOOKUP: begin
                    r_was_hit <= w_lookup_hit;
                    if (w_lookup_hit) begin
                        r_line_index <= w_match_way;
                        r_resp_data  <= r_data[w_match_way];
                    end else begin
                        r_fill_way <= w_fill_way;
                        r_mem_tag  <= r_req_tag;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_ack) begin
                        r_valid[r_fill_way] <= 1'b1;
                        r_resp_data         <= mem_data;
                    end
                end
                S_RESP: begin
                    if (!r_was_hit) begin
                        r_line_index <= r_fill_way;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays.
    // NOTE: storage has no reset; the valid bits alone mark contents as
    // meaningful, so clearing the arrays would only cost reset routing.
    always_ff @(posedge clk) begin
        if (w_fill_ack) begin
            r_tag[r_fill_way]  <= r_req_tag;
            r_data[r_fill_way] <= mem_data;
        end
    end

`ifdef CACHE_HIT_COUNTER_EN
    // Saturating lookup statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_lookup_hit) begin
                if (hit_cnt != 16'hFFFF) begin
                    hit_cnt <= hit_cnt + 16'd1;
                end
            end else begin
                if (miss_cnt != 16'hFFFF) begin
                    miss_cnt <= miss_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_tag_lookup.sv
// -----------------------------------------------------------------------------
// tb_cache_tag_lookup
//
// Self-checking bench for cache_tag_lookup. A reference model of the 4 ways
// predicts hit/miss, way and response data for each request. The prediction
// is pushed to a scoreboard queue when the request is driven and popped by a
// monitor when resp_valid is seen. Each scenario task also checks the cycle
// timing of its own handshake inline.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cache_tag_lookup;

    localparam int TAG_W  = 8;
    localparam int DATA_W = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              was_hit;
        logic [1:0]        idx;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic [TAG_W-1:0]  req_tag;
    logic              req_ready;
    logic [1:0]        lru_way;
    logic              hit;
    logic [1:0]        line_index;
    logic              lru_update;
    logic              mem_req;
    logic [TAG_W-1:0]  mem_tag;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
`ifdef CACHE_HIT_COUNTER_EN
    logic [15:0]       hit_cnt;
    logic [15:0]       miss_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t sb_q[$];

    // Reference model of the cache contents
    logic              m_valid [4];
    logic [TAG_W-1:0]  m_tag   [4];
    logic [DATA_W-1:0] m_data  [4];

    cache_tag_lookup #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .lru_way    (lru_way),
        .hit        (hit),
        .line_index (line_index),
        .lru_update (lru_update),
        .mem_req    (mem_req),
        .mem_tag    (mem_tag),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data)
`ifdef CACHE_HIT_COUNTER_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: compares every response against the oldest prediction
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            n_tests = n_tests + 1;
            if (sb_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL resp_unexpected: resp_valid=1 data=%0h with no request outstanding", resp_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (resp_data !== e.data || hit !== 1'b0 || lru_update !== !e.was_hit ||
                    line_index !== e.idx) begin
                    n_fail = n_fail + 1;
                    $display("FAIL resp_compare: got data=%0h hit=%0b lru_update=%0b line_index=%0d, expected data=%0h hit=0 lru_update=%0b line_index=%0d",
                             resp_data, hit, lru_update, line_index, e.data, !e.was_hit, e.idx);
                end
            end
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    endfunction

    // One complete request. Called at a negedge; returns at the negedge of the
    // cycle after RESP, where req_ready should be 1 again.
    task automatic do_access(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] fill_data,
                             input int ack_delay);
        exp_t       e;
        logic       exp_hit;
        logic [1:0] exp_idx;
        int         waited;
        exp_hit = 1'b0;
        exp_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m_valid[i] && m_tag[i] == tag) begin
                exp_hit = 1'b1;
                exp_idx = 2'(i);
            end
        end
        if (!exp_hit) begin
            exp_idx = lru_way;
            for (int i = 3; i >= 0; i--) if (!m_valid[i]) exp_idx = 2'(i);
        end
        e.was_hit = exp_hit;
        e.idx     = exp_idx;
        e.data    = exp_hit ? m_data[exp_idx] : fill_data;

        waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout: req_ready=%0b after %0d cycles, expected 1", req_ready, waited);
        end

        sb_q.push_back(e);
        if (!exp_hit) begin
            m_valid[exp_idx] = 1'b1;
            m_tag[exp_idx]   = tag;
            m_data[exp_idx]  = fill_data;
        end
        req_valid = 1'b1;
        req_tag   = tag;
        @(posedge clk);
        #1 req_valid = 1'b0;

        // LOOKUP cycle
        @(negedge clk);
        n_tests++;
        if (hit !== exp_hit || lru_update !== exp_hit || mem_req !== 1'b0 || req_ready !== 1'b0 ||
            (exp_hit && line_index !== exp_idx)) begin
            n_fail++;
            $display("FAIL lookup_%0h: got hit=%0b lru_update=%0b line_index=%0d mem_req=%0b req_ready=%0b, expected hit=%0b lru_update=%0b line_index=%0d mem_req=0 req_ready=0",
                     tag, hit, lru_update, line_index, mem_req, req_ready, exp_hit, exp_hit, exp_idx);
        end

        if (!exp_hit) begin
            for (int k = 1; k <= ack_delay; k++) begin
                @(negedge clk);
                n_tests++;
                if (mem_req !== 1'b1 || mem_tag !== tag || resp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mem_wait_%0h_cycle%0d: got mem_req=%0b mem_tag=%0h resp_valid=%0b, expected mem_req=1 mem_tag=%0h resp_valid=0",
                             tag, k, mem_req, mem_tag, resp_valid, tag);
                end
                if (k == ack_delay) begin
                    mem_ack  = 1'b1;
                    mem_data = fill_data;
                end
            end
            @(posedge clk);
            #1 begin
                mem_ack  = 1'b0;
                mem_data = 8'h5C;
            end
        end

        // RESP cycle (data checked by the monitor)
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_timing_%0h: got resp_valid=%0b mem_req=%0b, expected resp_valid=1 mem_req=0",
                     tag, resp_valid, mem_req);
        end

        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || lru_update !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_return_%0h: got req_ready=%0b resp_valid=%0b lru_update=%0b, expected 1 0 0",
                     tag, req_ready, resp_valid, lru_update);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_tag   = '0;
        lru_way   = 2'd3;
        mem_ack   = 1'b0;
        mem_data  = '0;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || hit !== 1'b0 || mem_req !== 1'b0 || resp_valid !== 1'b0 ||
            lru_update !== 1'b0 || line_index !== 2'd0 || mem_tag !== '0 || resp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got ready=%0b hit=%0b mem_req=%0b resp_valid=%0b lru_update=%0b line_index=%0d mem_tag=%0h resp_data=%0h, expected 1 0 0 0 0 0 0 0",
                     req_ready, hit, mem_req, resp_valid, lru_update, line_index, mem_tag, resp_data);
        end
    endtask

    task automatic test_cold_miss();
        lru_way = 2'd3;
        do_access(8'h10, 8'hA5, 3);
    endtask

    task automatic test_fill_and_hit();
        lru_way = 2'd3;
        do_access(8'h11, 8'hB1, 2);
        do_access(8'h12, 8'hB2, 1);
        do_access(8'h13, 8'hB3, 4);
        do_access(8'h12, 8'h00, 0);
    endtask

    task automatic test_lru_replace();
        lru_way = 2'd1;
        do_access(8'h14, 8'hC4, 1);
        lru_way = 2'd3;
        do_access(8'h11, 8'hD1, 2);
        do_access(8'h14, 8'h00, 0);
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = cyc;
        do_access(8'h10, 8'h00, 0);
        do_access(8'h12, 8'h00, 0);
        do_access(8'h14, 8'h00, 0);
        n_tests++;
        if (cyc - t0 !== 9) begin
            n_fail++;
            $display("FAIL back_to_back_rate: got %0d cycles for 3 hits, expected 9", cyc - t0);
        end
    endtask

    task automatic test_reset_mem_wait();
        req_valid = 1'b1;
        req_tag   = 8'h16;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_mem_req: got mem_req=%0b, expected 1", mem_req);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1 || mem_tag !== '0 || resp_data !== '0 ||
            line_index !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: got mem_req=%0b ready=%0b mem_tag=%0h resp_data=%0h line_index=%0d, expected 0 1 0 0 0",
                     mem_req, req_ready, mem_tag, resp_data, line_index);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_ack  = 1'b1;
        mem_data = 8'hEE;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL late_ack: got resp_valid=%0b mem_req=%0b ready=%0b, expected 0 0 1",
                     resp_valid, mem_req, req_ready);
        end
        lru_way = 2'd2;
        do_access(8'h10, 8'h77, 2);
    endtask

`ifdef CACHE_HIT_COUNTER_EN
    task automatic test_counters();
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        lru_way = 2'd3;
        do_access(8'h40, 8'h01, 1);
        do_access(8'h41, 8'h02, 1);
        do_access(8'h40, 8'h00, 0);
        do_access(8'h41, 8'h00, 0);
        do_access(8'h40, 8'h00, 0);
        n_tests++;
        if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL counters: got hit_cnt=%0d miss_cnt=%0d, expected 3 2", hit_cnt, miss_cnt);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL counters_reset: got hit_cnt=%0d miss_cnt=%0d, expected 0 0", hit_cnt, miss_cnt);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_fill_and_hit();
        test_lru_replace();
        test_back_to_back();
        test_reset_mem_wait();
`ifdef CACHE_HIT_COUNTER_EN
        test_counters();
`endif
        repeat (2) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
